// File: rtl/led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
// Shared definitions for the memory-mapped LED PWM controller:
//   - word addresses of the control registers
//   - bus handshake FSM state encoding
// -----------------------------------------------------------------------------
package led_pwm_pkg;

    localparam logic [5:0] ADDR_ENABLE       = 6'd0;
    localparam logic [5:0] ADDR_BLINK_MASK   = 6'd1;
    localparam logic [5:0] ADDR_BLINK_PERIOD = 6'd2;
    localparam logic [5:0] ADDR_DUTY0        = 6'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE
    } bus_state_t;

endpackage

// File: rtl/led_pwm_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_channel
// One LED channel: software-visible duty register, a shadow copy that is only
// refreshed at frame start, the phase comparator and the enable/blank gating.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   write, wdata  duty register write strobe and value
//   frame_start   high in the cycle before phase wraps to 0
//   phase         shared PWM phase
//   enable        channel enable bit
//   blank         blink gating (1 = force dark)
//   duty          current duty register value (for readback)
//   lit           combinational LED state, registered by the top level
// -----------------------------------------------------------------------------
module led_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write,
    input  logic [PWM_BITS-1:0] wdata,
    input  logic                frame_start,
    input  logic [PWM_BITS-1:0] phase,
    input  logic                enable,
    input  logic                blank,
    output logic [PWM_BITS-1:0] duty,
    output logic                lit
);

    logic [PWM_BITS-1:0] active;

    // The shadow takes the register value sampled before this edge, so a write
    // landing on the frame-start edge only shows up one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty   <= '1;
            active <= '1;
        end else begin
            if (write)
                duty <= wdata;
            if (frame_start)
                active <= duty;
        end
    end

    // All-ones is special-cased so that full brightness has no dark phase.
    always_comb begin
        lit = enable & ((active == '1) | (phase < active)) & ~blank;
    end

endmodule

// File: rtl/led_pwm.sv
// -----------------------------------------------------------------------------
// led_pwm
// Memory-mapped LED controller with per-channel PWM brightness and optional
// per-channel blink gating.
// Ports:
//   i_clock, i_reset_n     clock, asynchronous active-low reset
//   i_request, i_rw        bus request (held until o_ready), 1 = write
//   i_address, i_wdata     word address and write data
//   o_rdata, o_ready       read data and one-cycle acknowledge
//   LEDR                   registered LED drive, 1 = lit
// Configuration macro: LED_PWM_BLINK_EN enables the blink mask/period
// registers and blink counter; without it addresses 1 and 2 read as 0.
// -----------------------------------------------------------------------------
module led_pwm
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS = 10,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 64
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_request,
    input  logic                i_rw,
    input  logic [5:0]          i_address,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata,
    output logic                o_ready,
    output logic [NUM_LEDS-1:0] LEDR
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] phase;
    logic                tick;
    logic                frame_start;

    bus_state_t          state;
    logic [5:0]          acc_addr;
    logic                acc_read;
    logic                wr_go;
    logic [31:0]         rd_word;

    logic [NUM_LEDS-1:0] enable;
    logic [NUM_LEDS-1:0] blank;
    logic [NUM_LEDS-1:0] lit;
    logic [PWM_BITS-1:0] duty [NUM_LEDS];

    // Only the low register-width bits of the write bus are meaningful.
    logic unused_wdata;
    assign unused_wdata = ^i_wdata;

    assign tick        = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign frame_start = tick & (phase == '1);

    // Writes commit on the edge where the idle FSM accepts the request.
    assign wr_go = (state == IDLE) & i_request & i_rw;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_cnt <= '0;
            phase   <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick)
                phase <= phase + PWM_BITS'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            enable <= '0;
        else if (wr_go && i_address == ADDR_ENABLE)
            enable <= i_wdata[NUM_LEDS-1:0];
    end

`ifdef LED_PWM_BLINK_EN
    logic [NUM_LEDS-1:0] blink_mask;
    logic [15:0]         blink_period;
    logic [15:0]         frame_cnt;
    logic                blink_off;

    // A period write restarts the blink cycle in the lit half; period 0 freezes
    // the counter since blinking is disabled anyway.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            blink_mask   <= '0;
            blink_period <= '0;
            frame_cnt    <= '0;
            blink_off    <= 1'b0;
        end else begin
            if (wr_go && i_address == ADDR_BLINK_MASK)
                blink_mask <= i_wdata[NUM_LEDS-1:0];
            if (wr_go && i_address == ADDR_BLINK_PERIOD) begin
                blink_period <= i_wdata[15:0];
                frame_cnt    <= '0;
                blink_off    <= 1'b0;
            end else if (frame_start && blink_period != 16'd0) begin
                if (frame_cnt == blink_period - 16'd1) begin
                    frame_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

    assign blank = blink_mask & {NUM_LEDS{blink_off & (blink_period != 16'd0)}};
`else
    assign blank = '0;
`endif

    for (genvar n = 0; n < NUM_LEDS; n++) begin : g_chan
        localparam logic [5:0] DUTY_ADDR = ADDR_DUTY0 + 6'(n);

        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk        (i_clock),
            .rst_n      (i_reset_n),
            .write      (wr_go && i_address == DUTY_ADDR),
            .wdata      (i_wdata[PWM_BITS-1:0]),
            .frame_start(frame_start),
            .phase      (phase),
            .enable     (enable[n]),
            .blank      (blank[n]),
            .duty       (duty[n]),
            .lit        (lit[n])
        );
    end

    // Readback uses the address latched at accept time, so the data is stable
    // even if the master changes i_address while waiting for o_ready.
    always_comb begin
        rd_word = '0;
        if (acc_addr == ADDR_ENABLE)
            rd_word[NUM_LEDS-1:0] = enable;
`ifdef LED_PWM_BLINK_EN
        if (acc_addr == ADDR_BLINK_MASK)
            rd_word[NUM_LEDS-1:0] = blink_mask;
        if (acc_addr == ADDR_BLINK_PERIOD)
            rd_word[15:0] = blink_period;
`endif
        for (int n = 0; n < NUM_LEDS; n++) begin
            if (acc_addr == ADDR_DUTY0 + 6'(n))
                rd_word[PWM_BITS-1:0] = duty[n];
        end
    end

    // RELEASE holds off until the request drops, so a request left high
    // after its acknowledge is never taken a second time.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            o_ready  <= 1'b0;
            o_rdata  <= '0;
            acc_addr <= '0;
            acc_read <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            o_rdata <= '0;
            case (state)
                IDLE: begin
                    if (i_request) begin
                        acc_addr <= i_address;
                        acc_read <= ~i_rw;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    o_ready <= 1'b1;
                    o_rdata <= acc_read ? rd_word : 32'd0;
                    state   <= RELEASE;
                end
                RELEASE: begin
                    if (!i_request)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            LEDR <= '0;
        else
            LEDR <= lit;
    end

endmodule
